// File: rtl/nn_eval_pkg.sv
// nn_eval_pkg
// Shared definitions for the network evaluation blocks: the scoreboard FSM
// state encoding, an index-width helper and the default dataset geometry
// (750 labelled samples, 8-bit labels, 10 classes).
package nn_eval_pkg;

    localparam int DEF_N_SAMPLES = 750;
    localparam int DEF_LABEL_W   = 8;
    localparam int DEF_N_CLASSES = 10;
    localparam int DEF_CNT_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Address/select width for a table of n entries; never less than one bit
    // so single-entry configurations still produce a legal port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/label_table.sv
// label_table
// Expected-label store: DEPTH x WIDTH register array, one synchronous write
// port and one combinational read port so the scoreboard can look up the
// label of the current sample in the same cycle the prediction arrives.
// Contents are deliberately not reset; the table survives reset and runs.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable (caller guarantees waddr < DEPTH)
//   waddr  - write address
//   wdata  - label to store
//   raddr  - read address (caller guarantees raddr < DEPTH)
//   rdata  - label at raddr, combinational
module label_table
    import nn_eval_pkg::*;
#(
    parameter int DEPTH = DEF_N_SAMPLES,
    parameter int WIDTH = DEF_LABEL_W,
    localparam int AW   = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/accuracy_monitor.sv
// accuracy_monitor
// Classification scoreboard. Holds a table of expected labels and compares
// one predicted class per result_valid strobe against label[idx], counting
// total and correct classifications and per-expected-class misses.
// Ports:
//   clk, rst          - clock (rising edge); asynchronous active-low reset
//   lbl_we/addr/data  - label table write (IDLE/DONE only, addr < N_SAMPLES)
//   start             - clear counters and begin (or restart) a run
//   result_valid      - strobe: result holds a new prediction
//   result            - predicted class
//   result_ready      - strobe will be accepted (RUN)
//   busy / done       - in RUN / in DONE
//   total_count       - accepted results
//   correct_count     - accepted results matching their label
//   bad_class         - sticky: an accepted result was >= N_CLASSES
//   class_sel         - selects the class shown on class_miss
//   class_miss        - miss count of expected class class_sel (combinational)
module accuracy_monitor
    import nn_eval_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int LABEL_W   = DEF_LABEL_W,
    parameter int N_CLASSES = DEF_N_CLASSES,
    parameter int CNT_W     = DEF_CNT_W,
    localparam int IDX_W    = idx_width(N_SAMPLES),
    localparam int CLS_W    = idx_width(N_CLASSES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lbl_we,
    input  logic [IDX_W-1:0]   lbl_addr,
    input  logic [LABEL_W-1:0] lbl_data,
    input  logic               start,
    input  logic               result_valid,
    input  logic [LABEL_W-1:0] result,
    output logic               result_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   total_count,
    output logic [CNT_W-1:0]   correct_count,
    output logic               bad_class,
    input  logic [CLS_W-1:0]   class_sel,
    output logic [CNT_W-1:0]   class_miss
);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   total_reg, correct_reg;
    logic               bad_reg;
    logic [LABEL_W-1:0] exp_label;
    logic [CNT_W-1:0]   miss_arr [N_CLASSES];

    logic tbl_we, accept, last, result_ok, hit, miss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The table is frozen during a run; out-of-range writes are dropped here
    // so the array never sees an illegal address.
    assign tbl_we = lbl_we && (state_reg != ST_RUN) && (32'(lbl_addr) < N_SAMPLES);

    label_table #(
        .DEPTH (N_SAMPLES),
        .WIDTH (LABEL_W)
    ) u_label_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (lbl_addr),
        .wdata (lbl_data),
        .raddr (idx_reg),
        .rdata (exp_label)
    );

    // A start in RUN takes priority: the coincident strobe is dropped.
    assign accept    = (state_reg == ST_RUN) && result_valid && !start;
    assign last      = (idx_reg == IDX_W'(N_SAMPLES - 1));
    // An illegal prediction is never correct, even if the label is equally illegal.
    assign result_ok = (32'(result) < N_CLASSES);
    assign hit       = accept && result_ok && (result == exp_label);
    assign miss      = accept && !(result_ok && (result == exp_label));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (start)               state_next = ST_RUN;
                else if (accept && last) state_next = ST_DONE;
            end
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy         = (state_reg == ST_RUN);
        result_ready = (state_reg == ST_RUN);
        done         = (state_reg == ST_DONE);
    end

    // ---------------- index and global counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg     <= '0;
            total_reg   <= '0;
            correct_reg <= '0;
            bad_reg     <= 1'b0;
        end else if (start) begin
            idx_reg     <= '0;
            total_reg   <= '0;
            correct_reg <= '0;
            bad_reg     <= 1'b0;
        end else if (accept) begin
            // Wrap to 0 after the final sample so the table read stays in range in DONE.
            idx_reg   <= last ? '0 : idx_reg + 1'b1;
            total_reg <= sat_inc(total_reg);
            if (hit)        correct_reg <= sat_inc(correct_reg);
            if (!result_ok) bad_reg     <= 1'b1;
        end
    end

    // ---------------- per-class miss counters ----------------
    // A miss is charged to the expected class; an out-of-range label matches
    // no counter and is therefore not charged anywhere.
    genvar gi;
    generate
        for (gi = 0; gi < N_CLASSES; gi++) begin : g_miss
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (start) begin
                    cnt_reg <= '0;
                end else if (miss && (32'(exp_label) == gi)) begin
                    cnt_reg <= sat_inc(cnt_reg);
                end
            end
            assign miss_arr[gi] = cnt_reg;
        end
    endgenerate

    assign class_miss    = (32'(class_sel) < N_CLASSES) ? miss_arr[class_sel] : '0;
    assign total_count   = total_reg;
    assign correct_count = correct_reg;
    assign bad_class     = bad_reg;

endmodule

// File: tb/tb_accuracy_monitor.sv
module tb_accuracy_monitor;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       lbl_we;
    logic [9:0] lbl_addr;
    logic [7:0] lbl_data;
    logic       start;
    logic       result_valid;
    logic [7:0] result;
    logic       result_ready;
    logic       busy;
    logic       done;
    logic [9:0] total_count;
    logic [9:0] correct_count;
    logic       bad_class;
    logic [3:0] class_sel;
    logic [9:0] class_miss;

    accuracy_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .lbl_we        (lbl_we),
        .lbl_addr      (lbl_addr),
        .lbl_data      (lbl_data),
        .start         (start),
        .result_valid  (result_valid),
        .result        (result),
        .result_ready  (result_ready),
        .busy          (busy),
        .done          (done),
        .total_count   (total_count),
        .correct_count (correct_count),
        .bad_class     (bad_class),
        .class_sel     (class_sel),
        .class_miss    (class_miss)
    );

    always #HALF clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string            name;
        bit               is_done;
        int               total;
        int               correct;
        int               bad;
        int               busy;
        int               dn;
        int               ready;
        logic [9:0][15:0] miss;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   passes    = 0;
    int   snap_cnt  = 0;
    int   snap_seen = 0;
    int   last_cyc  = 0;
    logic done_q    = 1'b0;

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    function automatic exp_t mk(input string nm, input bit is_done, input int t,
                                input int c, input int b, input int bs,
                                input int d, input int r);
        exp_t e;
        e.name = nm; e.is_done = is_done; e.total = t; e.correct = c;
        e.bad = b; e.busy = bs; e.dn = d; e.ready = r; e.miss = '0;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        bit   fire_done, fire_snap;
        class_sel = '0;
        forever begin
            @(negedge clk);
            fire_done = done && !done_q;
            done_q    = done;
            fire_snap = (snap_seen != snap_cnt);
            if (fire_snap) snap_seen++;
            if (fire_done || fire_snap) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL sb_empty: got an output event, expected none");
                end else begin
                    e = sb.pop_front();
                    $display("txn %s: total=%0d correct=%0d bad=%0d busy=%0d done=%0d",
                             e.name, total_count, correct_count, bad_class, busy, done);
                    check({e.name, ":kind"},    int'(fire_done),     int'(e.is_done));
                    check({e.name, ":total"},   int'(total_count),   e.total);
                    check({e.name, ":correct"}, int'(correct_count), e.correct);
                    check({e.name, ":bad"},     int'(bad_class),     e.bad);
                    check({e.name, ":busy"},    int'(busy),          e.busy);
                    check({e.name, ":ready"},   int'(result_ready),  e.ready);
                    check({e.name, ":done"},    int'(done),          e.dn);
                    if (e.is_done) check({e.name, ":done_lat"}, cyc, last_cyc + 1);
                    for (int k = 0; k < 10; k++) begin
                        class_sel = 4'(k);
                        #1;
                        check($sformatf("%s:miss%0d", e.name, k), int'(class_miss), int'(e.miss[k]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input exp_t e);
        sb.push_back(e);
        snap_cnt++;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: result = i%10; mode 1: result = 0; mode 2: as 0 but 12 at sample 3
    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            result_valid = 1'b1;
            case (mode)
                1:       result = 8'd0;
                2:       result = (i == 3) ? 8'd12 : 8'(i % 10);
                default: result = 8'(i % 10);
            endcase
            last_cyc = cyc;
            step();
        end
        result_valid = 1'b0;
    endtask

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL timeout: %0d expectations pending, expected 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; lbl_we = 1'b0; lbl_addr = '0; lbl_data = '0;
        start = 1'b0; result_valid = 1'b0; result = '0;
        repeat (3) step();
        snap(mk("reset", 0, 0, 0, 0, 0, 0, 0));
        step();
        rst = 1'b1;
        step();
        wait_sb_empty(10);

        for (int i = 0; i < 750; i++) begin
            lbl_we = 1'b1; lbl_addr = 10'(i); lbl_data = 8'(i % 10);
            step();
        end
        lbl_we = 1'b0;

        // strobes in IDLE are ignored
        repeat (3) begin result_valid = 1'b1; result = 8'd3; step(); end
        result_valid = 1'b0;
        snap(mk("idle_ignore", 0, 0, 0, 0, 0, 0, 0));
        step();
        wait_sb_empty(10);

        // all correct
        do_start();
        snap(mk("start_clear", 0, 0, 0, 0, 1, 0, 1));
        sb.push_back(mk("all_correct", 1, 750, 750, 0, 0, 1, 0));
        feed(750, 0);
        wait_sb_empty(50);

        // strobes in DONE are ignored
        repeat (3) begin result_valid = 1'b1; result = 8'd1; step(); end
        result_valid = 1'b0;
        snap(mk("done_ignore", 0, 750, 750, 0, 0, 1, 0));
        step();
        wait_sb_empty(10);

        // every prediction is class 0
        do_start();
        e = mk("all_zero", 1, 750, 75, 0, 0, 1, 0);
        for (int k = 1; k < 10; k++) e.miss[k] = 16'd75;
        sb.push_back(e);
        feed(750, 1);
        wait_sb_empty(50);

        // one illegal prediction at sample 3
        do_start();
        e = mk("bad_class", 1, 750, 749, 1, 0, 1, 0);
        e.miss[3] = 16'd1;
        sb.push_back(e);
        feed(750, 2);
        wait_sb_empty(50);

        // abort after 100 accepts; the coincident strobe is dropped
        do_start();
        feed(100, 1);
        start = 1'b1; result_valid = 1'b1; result = 8'd5;
        step();
        start = 1'b0; result_valid = 1'b0;
        snap(mk("abort", 0, 0, 0, 0, 1, 0, 1));
        sb.push_back(mk("after_abort", 1, 750, 750, 0, 0, 1, 0));
        feed(750, 0);
        wait_sb_empty(50);

        // label writes during RUN are ignored; reset mid-run
        do_start();
        for (int i = 0; i < 200; i++) begin
            result_valid = 1'b1; result = 8'(i % 10);
            lbl_we = 1'b1; lbl_addr = 10'd0; lbl_data = 8'd7;
            step();
        end
        result_valid = 1'b0; lbl_we = 1'b0;
        rst = 1'b0;
        snap(mk("reset_mid", 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        rst = 1'b1;
        step();
        wait_sb_empty(10);
        do_start();
        sb.push_back(mk("after_reset", 1, 750, 750, 0, 0, 1, 0));
        feed(750, 0);
        wait_sb_empty(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #(2 * HALF * 20000);
        $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
